// File: rtl/vl_sweep_pkg.sv
// Shared types for the VL sweep checker: input symbol encoding and sweep FSM states.
package vl_sweep_pkg;

   typedef logic [1:0] sym_t;

   localparam sym_t SYM_0 = 2'd0;
   localparam sym_t SYM_1 = 2'd1;
   localparam sym_t SYM_X = 2'd2;
   localparam sym_t SYM_Z = 2'd3;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   // Maps one sweep digit onto the 4-state value driven on an input bit.
   function automatic logic enc_sym(input sym_t s);
      case (s)
         SYM_0:   return 1'b0;
         SYM_1:   return 1'b1;
         SYM_X:   return 1'bx;
         default: return 1'bz;
      endcase
   endfunction

endpackage

// File: rtl/vl_sweep_lane_cmp.sv
// One compared output lane: exact 4-state inequality plus a saturating mismatch counter.
module vl_sweep_lane_cmp #(
   parameter int OUT_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             sample_en,
   input  logic [OUT_W-1:0] spec,
   input  logic [OUT_W-1:0] impl,
   output logic             mism,
   output logic [CNT_W-1:0] cnt
);

   // x against x counts as a match, x against z does not.
   assign mism = (spec !== impl);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (sample_en && mism && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vl_vector_sweep_checker.sv
// Sweeps every 4-state input vector through a spec/impl pair and tallies per-lane mismatches.
// Define VL_SWEEP_LOG_EN to print one line per failing lane during sampling.
module vl_vector_sweep_checker
   import vl_sweep_pkg::*;
#(
   parameter int IN_W   = 4,
   parameter int OUT_W  = 4,
   parameter int NLANE  = 6,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   output logic [IN_W-1:0]        in_vec,
   input  logic [NLANE*OUT_W-1:0] spec_bus,
   input  logic [NLANE*OUT_W-1:0] impl_bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NLANE*CNT_W-1:0] fail_cnt,
   output logic [IN_W-1:0]        first_in,
   output logic [NLANE-1:0]       first_mask
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t              state;
   logic [2*IN_W-1:0]   idx;
   logic [3:0]          settle_cnt;
   logic                first_seen;
   logic [NLANE-1:0]    mism;
   logic                start_ok;
   logic                sample_en;

   function automatic logic [IN_W-1:0] enc_vec(input logic [2*IN_W-1:0] i);
      logic [IN_W-1:0] v;
      for (int j = 0; j < IN_W; j++) begin
         v[j] = enc_sym(i[2*j +: 2]);
      end
      return v;
   endfunction

   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign sample_en = (state == SAMPLE);

   for (genvar k = 0; k < NLANE; k++) begin : g_lane
      vl_sweep_lane_cmp #(
         .OUT_W(OUT_W),
         .CNT_W(CNT_W)
      ) u_cmp (
         .clk      (clk),
         .reset_n  (reset_n),
         .clear    (start_ok),
         .sample_en(sample_en),
         .spec     (spec_bus[k*OUT_W +: OUT_W]),
         .impl     (impl_bus[k*OUT_W +: OUT_W]),
         .mism     (mism[k]),
         .cnt      (fail_cnt[k*CNT_W +: CNT_W])
      );
   end

   // in_vec only moves when a new DRIVE phase begins, so it is stable through SAMPLE and DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         in_vec     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         first_seen <= 1'b0;
         first_in   <= '0;
         first_mask <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= DRIVE;
                  idx        <= '0;
                  settle_cnt <= '0;
                  in_vec     <= enc_vec('0);
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  first_seen <= 1'b0;
                  first_in   <= '0;
                  first_mask <= '0;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if ((|mism) && !first_seen) begin
                  first_seen <= 1'b1;
                  first_in   <= in_vec;
                  first_mask <= mism;
               end
               if (idx == {2*IN_W{1'b1}}) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !(first_seen || (|mism));
               end else begin
                  state      <= DRIVE;
                  idx        <= idx + 1'b1;
                  in_vec     <= enc_vec(idx + 1'b1);
                  settle_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VL_SWEEP_LOG_EN
   always_ff @(posedge clk) begin
      if (reset_n && (state == SAMPLE)) begin
         for (int k = 0; k < NLANE; k++) begin
            if (mism[k]) begin
               $display("lane %0d fail: in = %b, spec = %b, impl = %b", k, in_vec,
                        spec_bus[k*OUT_W +: OUT_W], impl_bus[k*OUT_W +: OUT_W]);
            end
         end
      end
   end
`else
`endif

endmodule
